// File: rtl/uart_pkt_scheduler.sv
// uart_pkt_scheduler: buffers UART RX bytes in a FIFO and emits them to the
// WiFi transmit path as packets of {length header, payload} on a
// valid/ready byte stream. A packet starts on a size threshold, an idle
// timeout, or an explicit flush request.
module uart_pkt_scheduler #(
  parameter int DEPTH       = 64,
  parameter int PKT_MAX     = 32,
  parameter int IDLE_CYCLES = 1000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  input  logic                     flush_req,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     tx_last,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(IDLE_CYCLES + 1);

  localparam logic [LW-1:0] DEPTH_L   = LW'(DEPTH);
  localparam logic [LW-1:0] PKT_MAX_L = LW'(PKT_MAX);
  localparam logic [CW-1:0] IDLE_L    = CW'(IDLE_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_DATA
  } state_t;

  state_t        state_reg;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] idle_cnt_reg;
  logic [7:0]    len_reg;
  logic [7:0]    remaining_reg;

  logic          push;
  logic          pop;
  logic          start;
  logic [7:0]    start_len;
  logic [AW-1:0] rd_ptr_inc;

  // Decode FIFO push/pop, packet start condition and the packet length to latch.
  // Fullness is judged on the registered level, so a same-cycle pop never
  // makes room for an incoming byte.
  always_comb begin
    push       = rx_valid && (fifo_level != DEPTH_L);
    pop        = (state_reg == S_DATA) && tx_ready;
    start      = (state_reg == S_IDLE) && (fifo_level != '0) &&
                 ((fifo_level >= PKT_MAX_L) || (idle_cnt_reg == IDLE_L) || flush_req);
    start_len  = (fifo_level >= PKT_MAX_L) ? 8'(PKT_MAX) : 8'(fifo_level);
    rd_ptr_inc = rd_ptr_reg + AW'(1);
  end

  // Byte storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= rx_data;
    end
  end

  // FIFO pointers, registered level and the overflow pulse for dropped bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_inc;
      end
      overflow <= rx_valid && !push;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Idle counter: counts quiet cycles while data waits in IDLE, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt_reg <= '0;
    end else if (rx_valid || start) begin
      idle_cnt_reg <= '0;
    end else if ((state_reg == S_IDLE) && (fifo_level != '0) && (idle_cnt_reg != IDLE_L)) begin
      idle_cnt_reg <= idle_cnt_reg + CW'(1);
    end
  end

  // Packet sequencer: header then payload, all stream outputs registered.
  // The next payload byte is read ahead from the FIFO on each handshake; it is
  // always inside the latched length, so it was written before the packet began.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      len_reg       <= '0;
      remaining_reg <= '0;
      tx_data       <= '0;
      tx_valid      <= 1'b0;
      tx_last       <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            len_reg   <= start_len;
            tx_data   <= start_len;
            tx_valid  <= 1'b1;
            tx_last   <= 1'b0;
            state_reg <= S_HDR;
          end
        end
        S_HDR: begin
          if (tx_ready) begin
            remaining_reg <= len_reg;
            tx_data       <= mem[rd_ptr_reg];
            tx_last       <= (len_reg == 8'd1);
            state_reg     <= S_DATA;
          end
        end
        S_DATA: begin
          if (tx_ready) begin
            remaining_reg <= remaining_reg - 8'd1;
            if (remaining_reg == 8'd1) begin
              tx_valid  <= 1'b0;
              tx_data   <= '0;
              tx_last   <= 1'b0;
              state_reg <= S_IDLE;
            end else begin
              tx_data <= mem[rd_ptr_inc];
              tx_last <= (remaining_reg == 8'd2);
            end
          end
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_pkt_scheduler.sv
// Testbench for uart_pkt_scheduler: directed stimulus pushes the expected
// {last, byte} stream into a scoreboard queue; a monitor on the falling edge
// pops and compares on every tx handshake and checks stall stability.
module tb_uart_pkt_scheduler;

  localparam int DEPTH       = 64;
  localparam int PKT_MAX     = 32;
  localparam int IDLE_CYCLES = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        flush_req = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        tx_last;
  logic [$clog2(DEPTH):0] fifo_level;
  logic        overflow;

  int checks   = 0;
  int failures = 0;
  int ovf_cnt  = 0;
  int txn      = 0;

  logic [8:0] sb[$];          // expected {tx_last, tx_data}
  logic [8:0] exp_v;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  logic       prev_last = 1'b0;
  logic       rand_ready = 1'b0;

  uart_pkt_scheduler #(
    .DEPTH(DEPTH),
    .PKT_MAX(PKT_MAX),
    .IDLE_CYCLES(IDLE_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .flush_req(flush_req),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_last(tx_last),
    .fifo_level(fifo_level),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input logic l);
    sb.push_back({l, d});
  endtask

  // Header byte n, then n payload bytes first, first+1, ... with last on the final one.
  task automatic push_pkt(input logic [7:0] first, input int n);
    push_exp(8'(n), 1'b0);
    for (int i = 0; i < n; i++) begin
      push_exp(8'(int'(first) + i), (i == n - 1));
    end
  endtask

  // Back-to-back rx strobes carrying first, first+1, ...; starts and ends at posedge+1.
  task automatic burst(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      rx_data  = 8'(int'(first) + i);
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
    rx_data  = '0;
  endtask

  task automatic pulse_flush;
    flush_req = 1'b1;
    @(posedge clk);
    #1;
    flush_req = 1'b0;
  endtask

  // Wait until every expected byte has been seen and the stream is idle.
  task automatic wait_drain(input string name, input int budget);
    logic done;
    done = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && !tx_valid) begin
        done = 1'b1;
        break;
      end
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s: drain timeout, %0d bytes still expected, required 0", name, sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  // Random backpressure, active only while rand_ready is set.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) tx_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: stream comparison, stall stability, idle-data and overflow counting.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_hold", {tx_valid, tx_last, tx_data}, {1'b1, prev_last, prev_data});
      end
      if (!tx_valid) begin
        check("idle_data_zero", {tx_last, tx_data}, 9'd0);
      end
      if (overflow) ovf_cnt++;
      if (tx_valid && tx_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_byte: got data=0x%02h last=%0b, expected no byte", tx_data, tx_last);
        end else begin
          exp_v = sb.pop_front();
          txn++;
          $display("txn %0d: data=0x%02h last=%0b (expected 0x%02h last=%0b)",
                   txn, tx_data, tx_last, exp_v[7:0], exp_v[8]);
          check("stream", {tx_last, tx_data}, exp_v);
        end
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      prev_last  = tx_last;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    int ovf0;
    logic seen;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_tx_last", tx_last, 0);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_overflow", overflow, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: three bytes then quiet; counter saturates 20 edges after the last
    // write, and the start is taken on the edge after that (21st edge).
    tx_ready = 1'b1;
    push_pkt(8'h41, 3);
    burst(8'h41, 3);
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (tx_valid) begin
        n = i;
        break;
      end
    end
    check("idle_timeout_cycles", n, 21);
    wait_drain("t1_drain", 100);

    // 2: 40 bytes -> threshold packet of 32, then idle packet of 8.
    push_pkt(8'h00, 32);
    push_pkt(8'h20, 8);
    burst(8'h00, 40);
    wait_drain("t2_drain", 300);

    // 3: 200 bytes in groups of 25 under random backpressure, each flushed.
    rand_ready = 1'b1;
    for (int g = 0; g < 8; g++) begin
      push_pkt(8'(g * 25), 25);
      burst(8'(g * 25), 25);
      check("t3_level", fifo_level, 25);
      pulse_flush();
      wait_drain("t3_drain", 500);
    end
    rand_ready = 1'b0;
    tx_ready   = 1'b0;

    // 4: 70 bytes with the sink stalled -> saturate at 64, 6 drops.
    push_pkt(8'h00, 32);
    push_pkt(8'h20, 32);
    ovf0 = ovf_cnt;
    burst(8'h00, 70);
    @(negedge clk);
    @(negedge clk);
    check("t4_level_sat", fifo_level, 64);
    check("t4_overflow_pulses", ovf_cnt - ovf0, 6);
    check("t4_header_stalled", {tx_valid, tx_data}, {1'b1, 8'h20});
    @(posedge clk);
    #1;
    tx_ready = 1'b1;
    wait_drain("t4_drain", 300);
    check("t4_level_empty", fifo_level, 0);

    // 5: flush with 5 buffered bytes; then flush with nothing buffered.
    push_pkt(8'hA0, 5);
    burst(8'hA0, 5);
    @(posedge clk);
    #1;
    check("t5_level", fifo_level, 5);
    pulse_flush();
    check("t5_flush_header", {tx_valid, tx_data}, {1'b1, 8'h05});
    wait_drain("t5_drain", 100);
    pulse_flush();
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (tx_valid) seen = 1'b1;
    end
    check("t5_empty_flush_ignored", seen, 0);
    @(posedge clk);
    #1;

    // 6: reset in DATA after header and two payload bytes.
    tx_ready = 1'b0;
    push_exp(8'h0A, 1'b0);
    push_exp(8'h60, 1'b0);
    push_exp(8'h61, 1'b0);
    burst(8'h60, 10);
    pulse_flush();
    check("t6_packet_started", tx_valid, 1);
    tx_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    tx_ready = 1'b0;
    @(negedge clk);
    check("t6_mid_payload", {tx_valid, tx_last, tx_data}, {1'b1, 1'b0, 8'h62});
    rst = 1'b1;
    #1;
    check("t6_rst_tx_valid", tx_valid, 0);
    check("t6_rst_tx_data", tx_data, 0);
    check("t6_rst_fifo_level", fifo_level, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t6_sb_consumed", sb.size(), 0);
    tx_ready = 1'b1;
    push_pkt(8'h55, 1);
    burst(8'h55, 1);
    pulse_flush();
    wait_drain("t6_drain", 100);

    check("final_sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
